instr_align_queue: RTL and testbench
====================================

# instr_align_queue

Halfword-granular instruction alignment queue between instruction fetch and decode. It is the successor to the fixed 32-bit instruction packet path. It accepts aligned fetch blocks of `FETCH_HW` halfwords and extracts variable-length instructions: 16-bit RVC, 32-bit, and reserved ≥48-bit encodings. It handles instructions that straddle fetch blocks and presents them one at a time to decode as `instructions_pkg::instr_packet` with their PC.

## Interface
Parameters:
- `FETCH_HW`, default 2: halfwords per fetch block. Allowed values are 1, 2 or 4 (16/32/64-bit fetch).
- `DEPTH_HW`, default 8: queue capacity in halfwords. Must be a power of two and ≥ 2*`FETCH_HW`.
- `RESET_PC`, default 32'h0000_0000: PC of the first instruction after reset. Bit 0 must be 0.

Ports (the one clock; reset is asynchronous, active-high):
- `clk` in 1: clock.
- `rst` in 1: asynchronous active-high reset.
- `fetch_valid` in 1: a fetch block is presented.
- `fetch_ready` out 1: the queue can accept a full block this cycle.
- `fetch_data` in 16*`FETCH_HW`: block data. The lowest halfword is at the lowest address, and the block address is aligned to the block size.
- `flush` in 1: redirect. Discards queue contents.
- `flush_pc` in 32: new PC. Bit 0 is ignored.
- `instr_valid` out 1: a complete instruction (or a length error) is at the head.
- `instr_ready` in 1: decode consumes the head.
- `instr` out 32: head instruction as `instr_packet`. Bits [31:16] are zero for 16-bit instructions.
- `instr_pc` out 32: PC of the head instruction.
- `instr_len` out 2: `instr_len_t` of the head instruction.

## Operation
- Storage is a circular buffer of `DEPTH_HW` halfwords with read pointer, write pointer and `count` (width $clog2(`DEPTH_HW`)+1). Pointers wrap modulo `DEPTH_HW`.
- Length is decoded from the head halfword h0:
  - h0[1:0] != 2'b11 → INSTR_LEN_16.
  - h0[1:0] == 2'b11 and h0[4:2] != 3'b111 → INSTR_LEN_32.
  - h0[4:0] == 5'b11111 → INSTR_LEN_ILLEGAL.
- `instr_valid` is asserted under these conditions:
  - count ≥ 1 and length is 16 or ILLEGAL;
  - count ≥ 2 and length is 32.
- A 32-bit instruction with only one halfword present stays invalid until the next block arrives.
- Pop on `instr_valid && instr_ready`:
  - Consumes 2 halfwords for INSTR_LEN_32 and 1 halfword otherwise.
  - `instr_pc` advances by 4 or 2 respectively.
  - ILLEGAL is passed to decode, which raises illegal-instruction. Downstream flushes after it.
- `fetch_ready` = (`DEPTH_HW` - count ≥ `FETCH_HW`) && !`flush`. It is computed from registered state only and does not depend on a same-cycle pop.
- Push on `fetch_valid && fetch_ready` writes `FETCH_HW` halfwords, with one exception. If the `skip` flag is set, the lowest halfword is dropped and `FETCH_HW`-1 halfwords are written. `skip` then clears.
- With `FETCH_HW`=1 and `skip` set, the block is dropped entirely and `skip` clears.
- A push and a pop in the same cycle are both performed: count += pushed − popped.
- Flush has the highest priority and takes effect at the clock edge:
  - count ← 0, and both pointers ← 0;
  - PC ← {`flush_pc`[31:1],1'b0};
  - `skip` ← `flush_pc`[1] when `FETCH_HW` ≥ 2. For `FETCH_HW`=1, `skip` ← 0.
  - Any same-cycle pop is ignored, and `instr_ready` has no effect.
- The fetch unit re-fetches from `flush_pc` aligned down to the block size.

## Timing
- Reset values: count=0, pointers=0, PC=`RESET_PC`, `skip`=`RESET_PC`[1].
- Output reset values: `instr_valid`=0, `fetch_ready`=1, `instr`=0, `instr_pc`=`RESET_PC`, `instr_len`=INSTR_LEN_16.
- Push-to-valid latency is 1 cycle. Data pushed at edge N is visible at the head after edge N.
- Outputs are combinational from registered state. There is no combinational path from `fetch_*` or `instr_ready` to any output.
- Throughput is one instruction per cycle. Steady state with 32-bit instructions and `FETCH_HW`=2 sustains 1 instruction per cycle.
- After a flush at edge N, `instr_valid`=0 in cycle N+1. The first new instruction is valid no earlier than cycle N+2.
- Reset asserted mid-operation immediately clears all state to the reset values, asynchronously.

## Structure
- Additions to `instructions_pkg`:
  - `typedef enum logic[1:0] instr_len_t {INSTR_LEN_16, INSTR_LEN_32, INSTR_LEN_ILLEGAL}`;
  - `HALFWORD_WIDTH` = 16;
  - `RVC_QUADRANT_MASK` = 2'b11.
- One combinational sub-module, `instr_len_decode` (16-bit halfword in, `instr_len_t` out). The compressed-expander stage will reuse it.
- Storage is a flop array. No SRAM macro at this depth.

## Test plan
- Reset then push 32'h0051_0093 (addi, `FETCH_HW`=2): `instr_valid`=1 next cycle, `instr`=32'h0051_0093, `instr_pc`=0, `instr_len`=INSTR_LEN_32.
- Push 32'h4505_4501 (two c.li): two pops, `instr_pc` 0 then 2, `instr` 32'h0000_4501 then 32'h0000_4505, `instr_len`=INSTR_LEN_16 both.
- Straddle case:
  - Push 32'h0093_4501: c.li at PC 0, then the low half of a 32-bit instruction.
  - After the first pop, `instr_valid`=0.
  - Push 32'h0000_0051: the 32-bit instruction becomes valid with `instr`=32'h0051_0093 and `instr_pc`=2.
- Flush with `flush_pc`=32'h0000_0102, then push the block at 0x100 = 32'h4505_4501: only c.li 32'h0000_4505 is emitted, at `instr_pc`=32'h102.
- Fill the queue with `instr_ready`=0 until count=`DEPTH_HW`: `fetch_ready`=0. A single pop of a 32-bit instruction does not re-raise `fetch_ready` until the following cycle. No data is lost and pointers wrap correctly.
- Head halfword 16'h001F: `instr_len`=INSTR_LEN_ILLEGAL, valid with count=1, consumes 1 halfword. Assert `rst` mid-stream: all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/instructions_pkg.sv
// Shared instruction-path types: packet format, length classes and RVC constants
// used by the alignment queue and later decode stages.
package instructions_pkg;

  localparam int unsigned HALFWORD_WIDTH = 16;
  localparam logic [1:0] RVC_QUADRANT_MASK = 2'b11;

  typedef logic [31:0] instr_packet;

  typedef enum logic [1:0] {
    INSTR_LEN_16,
    INSTR_LEN_32,
    INSTR_LEN_ILLEGAL
  } instr_len_t;

  // Halfwords consumed from the queue when an instruction of this length pops.
  function automatic logic [1:0] len_halfwords(input instr_len_t len);
    return (len == INSTR_LEN_32) ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/instr_len_decode.sv
// Instruction length classification from the first halfword of an instruction.
// Shared with the compressed-expander stage.
module instr_len_decode
  import instructions_pkg::*;
(
  input  logic [HALFWORD_WIDTH-1:0] hw,
  output instr_len_t                len
);

  always_comb begin
    len = INSTR_LEN_ILLEGAL;
    if ((hw[1:0] & RVC_QUADRANT_MASK) != RVC_QUADRANT_MASK) begin
      len = INSTR_LEN_16;
    end else if (hw[4:2] != 3'b111) begin
      len = INSTR_LEN_32;
    end
  end

endmodule

// File: rtl/instr_align_queue.sv
// Halfword circular queue between fetch and decode: accepts aligned fetch blocks and
// presents one variable-length instruction at a time with its PC.
module instr_align_queue
  import instructions_pkg::*;
#(
  parameter int unsigned FETCH_HW = 2,
  parameter int unsigned DEPTH_HW = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fetch_valid,
  output logic                         fetch_ready,
  input  logic [16*FETCH_HW-1:0]       fetch_data,
  input  logic                         flush,
  input  logic [31:0]                  flush_pc,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic [31:0]                  instr,
  output logic [31:0]                  instr_pc,
  output logic [1:0]                   instr_len
);

  localparam int unsigned AW = $clog2(DEPTH_HW);
  localparam int unsigned CW = AW + 1;

  logic [HALFWORD_WIDTH-1:0] mem [DEPTH_HW];
  logic [AW-1:0]             rd_ptr;
  logic [AW-1:0]             wr_ptr;
  logic [CW-1:0]             count;
  logic [31:0]               pc;
  logic                      skip;

  logic [HALFWORD_WIDTH-1:0] h0;
  logic [HALFWORD_WIDTH-1:0] h1;
  instr_len_t                head_len;
  logic                      pop;
  logic                      push;
  logic [CW-1:0]             pop_n;
  logic [CW-1:0]             push_n;

  assign h0 = mem[rd_ptr];
  assign h1 = mem[rd_ptr + AW'(1)];

  instr_len_decode u_len_decode (
    .hw  (h0),
    .len (head_len)
  );

  always_comb begin
    instr_valid = (count >= CW'(2)) || ((count == CW'(1)) && (head_len != INSTR_LEN_32));
    fetch_ready = ((CW'(DEPTH_HW) - count) >= CW'(FETCH_HW)) && !flush;
    pop         = instr_valid && instr_ready && !flush;
    push        = fetch_valid && fetch_ready;
    pop_n       = pop ? CW'(len_halfwords(head_len)) : '0;
    push_n      = push ? (skip ? CW'(FETCH_HW - 1) : CW'(FETCH_HW)) : '0;
    instr       = (head_len == INSTR_LEN_32) ? {h1, h0} : {16'h0000, h0};
    instr_pc    = pc;
    instr_len   = head_len;
  end

  // Storage is reset so the head reads as a zero 16-bit instruction out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH_HW; i++) mem[i] <= '0;
    end else if (push) begin
      for (int unsigned i = 0; i < FETCH_HW; i++) begin
        if (!skip) begin
          mem[wr_ptr + AW'(i)] <= fetch_data[i*HALFWORD_WIDTH +: HALFWORD_WIDTH];
        end else if (i >= 1) begin
          mem[wr_ptr + AW'(i - 1)] <= fetch_data[i*HALFWORD_WIDTH +: HALFWORD_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      pc     <= RESET_PC;
      skip   <= RESET_PC[1];
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      pc     <= {flush_pc[31:1], 1'b0};
      skip   <= (FETCH_HW >= 2) ? flush_pc[1] : 1'b0;
    end else begin
      rd_ptr <= rd_ptr + AW'(pop_n);
      wr_ptr <= wr_ptr + AW'(push_n);
      count  <= count + push_n - pop_n;
      if (pop) pc <= pc + {29'd0, pop_n[1:0], 1'b0};
      if (push) skip <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_align_queue.sv
// Randomized and directed bench for instr_align_queue against a queue-based reference model.
module tb_instr_align_queue;
  import instructions_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_valid = 1'b0;
  logic        fetch_ready;
  logic [31:0] fetch_data = '0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [1:0]  instr_len;

  instr_align_queue #(
    .FETCH_HW (2),
    .DEPTH_HW (8),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_data  (fetch_data),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_len   (instr_len)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] mq[$];
  logic [31:0] m_pc;
  logic        m_skip;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Length class from the first halfword: 0 = 16-bit, 1 = 32-bit, 2 = reserved/illegal.
  function automatic int ref_len_code(input logic [15:0] h);
    if (h[1:0] != 2'b11) return 0;
    if (h[4:2] != 3'b111) return 1;
    return 2;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc   = 32'h0;
    m_skip = 1'b0;
  endtask

  // Drive one cycle of inputs, compare outputs with the model, advance the model and the clock.
  task automatic step(input logic fv, input logic [31:0] fd, input logic ir,
                      input logic fl, input logic [31:0] fpc);
    int          sz;
    int          code;
    int          n;
    bit          v;
    bit          fr;
    logic [31:0] exp_instr;
    fetch_valid = fv;
    fetch_data  = fd;
    instr_ready = ir;
    flush       = fl;
    flush_pc    = fpc;
    #1;
    sz   = mq.size();
    code = (sz > 0) ? ref_len_code(mq[0]) : 0;
    v    = (sz >= 2) || (sz == 1 && code != 1);
    fr   = ((8 - sz) >= 2) && !fl;
    check("instr_valid", {31'd0, instr_valid}, {31'd0, v});
    check("fetch_ready", {31'd0, fetch_ready}, {31'd0, fr});
    check("instr_pc", instr_pc, m_pc);
    if (v) begin
      exp_instr = (code == 1) ? {mq[1], mq[0]} : {16'h0000, mq[0]};
      check("instr", instr, exp_instr);
      check("instr_len", {30'd0, instr_len}, code);
    end
    if (fl) begin
      mq.delete();
      m_pc   = {fpc[31:1], 1'b0};
      m_skip = fpc[1];
    end else begin
      if (v && ir) begin
        n = (code == 1) ? 2 : 1;
        repeat (n) void'(mq.pop_front());
        m_pc = m_pc + 32'(2 * n);
      end
      if (fv && fr) begin
        for (int i = 0; i < 2; i++)
          if (!(m_skip && i == 0)) mq.push_back(fd[16*i +: 16]);
        m_skip = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_fready"}, {31'd0, fetch_ready}, 32'd1);
    check({tag, "_instr"}, instr, 32'd0);
    check({tag, "_pc"}, instr_pc, 32'd0);
    check({tag, "_len"}, {30'd0, instr_len}, 32'd0);
  endtask

  initial begin
    #2;
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Single 32-bit addi
    step(1, 32'h0051_0093, 0, 0, 0);
    check("addi_valid", {31'd0, instr_valid}, 32'd1);
    check("addi_instr", instr, 32'h0051_0093);
    check("addi_pc", instr_pc, 32'h0);
    check("addi_len", {30'd0, instr_len}, 32'd1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 32'h0);
    check("flush_valid", {31'd0, instr_valid}, 32'd0);

    // Two c.li in one block
    step(1, 32'h4505_4501, 0, 0, 0);
    check("cli0_instr", instr, 32'h0000_4501);
    check("cli0_pc", instr_pc, 32'h0);
    check("cli0_len", {30'd0, instr_len}, 32'd0);
    step(0, 0, 1, 0, 0);
    check("cli1_instr", instr, 32'h0000_4505);
    check("cli1_pc", instr_pc, 32'h2);
    step(0, 0, 1, 0, 0);
    check("empty_valid", {31'd0, instr_valid}, 32'd0);

    // 32-bit instruction straddling two blocks
    step(0, 0, 0, 1, 32'h0);
    step(1, 32'h0093_4501, 0, 0, 0);
    check("strad_cli", instr, 32'h0000_4501);
    step(0, 0, 1, 0, 0);
    check("strad_half_valid", {31'd0, instr_valid}, 32'd0);
    step(1, 32'h0000_0051, 0, 0, 0);
    check("strad_valid", {31'd0, instr_valid}, 32'd1);
    check("strad_instr", instr, 32'h0051_0093);
    check("strad_pc", instr_pc, 32'h2);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);

    // Redirect to an odd-halfword PC inside a block
    step(0, 0, 0, 1, 32'h0000_0102);
    check("redir_valid", {31'd0, instr_valid}, 32'd0);
    step(1, 32'h4505_4501, 0, 0, 0);
    check("redir_instr", instr, 32'h0000_4505);
    check("redir_pc", instr_pc, 32'h102);
    step(0, 0, 1, 0, 0);
    check("redir_empty", {31'd0, instr_valid}, 32'd0);

    // Fill to capacity with decode stalled, then pop one 32-bit instruction
    repeat (4) step(1, 32'h0051_0093, 0, 0, 0);
    check("full_fready", {31'd0, fetch_ready}, 32'd0);
    step(1, 32'h0071_8193, 1, 0, 0);
    check("after_pop_fready", {31'd0, fetch_ready}, 32'd1);
    repeat (6) step(1, 32'h0071_8193, 1, 0, 0);
    repeat (6) step(0, 0, 1, 0, 0);

    // Reserved-length encoding at the head with a single halfword present
    step(0, 0, 0, 1, 32'h0);
    step(1, 32'h001F_4501, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    check("ill_valid", {31'd0, instr_valid}, 32'd1);
    check("ill_len", {30'd0, instr_len}, 32'd2);
    check("ill_instr", instr, 32'h0000_001F);
    step(0, 0, 1, 0, 0);
    check("ill_pc", instr_pc, 32'h4);
    check("ill_empty", {31'd0, instr_valid}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 31) == 0), $urandom);
    end

    // Asynchronous reset mid-stream
    step(0, 0, 0, 1, 32'h0000_0200);
    step(1, 32'h0051_0093, 0, 0, 0);
    step(1, 32'h4505_4501, 0, 0, 0);
    fetch_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(1, 32'h0051_0093, 0, 0, 0);
    step(0, 0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
